uart_alu_interface: RTL and testbench
=====================================

UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 SHALL have parameter N, default 8, ALU operand and result width; only N=8 is supported.
REQ-002 SHALL have parameter NB_OP, default 6, ALU opcode width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle cycles before a partial frame or stalled transmit is abandoned; 32-bit counter.
REQ-004 SHALL have ports clk (input, 1) and reset (input, 1): one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rx_done (input, 1): one-cycle strobe, byte valid on rx_data.
REQ-006 SHALL have port rx_data (input, 8): received byte.
REQ-007 SHALL have port tx_done (input, 1): one-cycle strobe, the transmitter finished its byte.
REQ-008 SHALL have ports alu_result (input, N), alu_zero, alu_overflow and alu_carry (input, 1 each): combinational ALU outputs.
REQ-009 SHALL have ports data_a (output, N), data_b (output, N) and op (output, NB_OP): registered ALU operands and opcode.
REQ-010 SHALL have ports tx_start (output, 1) and tx_data (output, 8): transmit request pulse and byte.
REQ-011 SHALL have port busy (output, 1), high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_B, WAIT_OP, EXEC, TX_RES, WAIT_RES, TX_FLG and WAIT_FLG.
REQ-013 IDLE: rx_done -> stage byte as A, go to WAIT_B; WAIT_B: rx_done -> stage B, go to WAIT_OP; WAIT_OP: rx_done -> stage opcode byte, go to EXEC.
REQ-014 Entry to EXEC SHALL be the edge that commits all three staged values together to data_a, data_b and op; a partial frame never alters these outputs.
REQ-015 Valid opcode bytes SHALL be 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA and 0x02 SRL; any other byte, including any with bits[7:6]!=0, is invalid.
REQ-016 An invalid opcode SHALL leave data_a, data_b and op unchanged and still run EXEC with captured result=0x00 and flags=0x80.
REQ-017 EXEC SHALL last exactly 1 cycle; at its closing edge it captures alu_result and flags byte {ERR=0, 4'b0, carry, overflow, zero}.
REQ-018 TX_RES SHALL last 1 cycle with tx_start=1 and tx_data=result, then go to WAIT_RES.
REQ-019 WAIT_RES: tx_done -> TX_FLG (1 cycle, tx_start=1, tx_data=flags) -> WAIT_FLG; WAIT_FLG: tx_done -> IDLE.
REQ-020 tx_start SHALL be a registered output, high only in TX_RES and TX_FLG, and never high on 2 consecutive cycles.
REQ-021 tx_data SHALL hold its last value outside TX states.
REQ-022 Latency: rx_done of the opcode byte at cycle t -> commit at t+1 -> tx_start for the result at t+2.
REQ-023 rx_done SHALL be ignored in EXEC, TX_RES, WAIT_RES, TX_FLG and WAIT_FLG (byte dropped, no staging).
REQ-024 tx_done SHALL be ignored outside WAIT_RES and WAIT_FLG.
REQ-025 The timeout counter SHALL clear on every state change and count in WAIT_B, WAIT_OP, WAIT_RES and WAIT_FLG.
REQ-026 Reaching TIMEOUT_CYCLES SHALL return the FSM to IDLE, discard staging and assert no tx_start.
REQ-027 rx_done and timeout expiry on the same cycle SHALL give priority to rx_done.

Reset
REQ-028 reset SHALL immediately force: state IDLE, data_a=0, data_b=0, op=0, tx_start=0, tx_data=0x00, busy=0, staging and counter cleared.
REQ-029 Reset asserted mid-frame or mid-transmit SHALL abort the operation without any further tx_start; the first rx_done after release is byte A.

Verification
REQ-030 Bytes 0x2A, 0x11, 0x20 -> data_a=42, data_b=17, op=6'b100000; tx bytes 0x3B then 0x00; tx_start 2 cycles after the third rx_done.
REQ-031 Bytes 0x05, 0x05, 0x22 -> tx 0x00 then 0x01 (Z).
REQ-032 Bytes 0xFF, 0x01, 0x20 -> tx 0x00 then 0x05 (C, Z); bytes 0x7F, 0x01, 0x20 -> tx 0x80 then 0x02 (V).
REQ-033 After a valid frame, bytes 0x01, 0x02, 0x3F -> tx 0x00 then 0x80; data_a, data_b and op keep their prior values.
REQ-034 With TIMEOUT_CYCLES=50: one byte, then 60 idle cycles -> busy=0, no tx_start; the next 3 bytes 0x0A, 0x03, 0x24 -> tx 0x02, 0x00.
REQ-035 Reset pulse in WAIT_RES -> all outputs 0 within the same cycle; extra rx_done during WAIT_FLG is dropped; a following frame behaves as REQ-030.

Source files
------------

// File: rtl/uart_alu_interface.sv
// UART-to-ALU bridge: collects operand A, operand B and an opcode byte from a UART
// receiver, drives an external ALU, and returns the result and flag bytes over the UART.
module uart_alu_interface #(
  parameter int N              = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             tx_done,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic [N-1:0]     data_a,
  output logic [N-1:0]     data_b,
  output logic [NB_OP-1:0] op,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    WAIT_OP,
    EXEC,
    TX_RES,
    WAIT_RES,
    TX_FLG,
    WAIT_FLG
  } state_t;

  localparam logic [7:0] OPC_ADD = 8'h20;
  localparam logic [7:0] OPC_SUB = 8'h22;
  localparam logic [7:0] OPC_AND = 8'h24;
  localparam logic [7:0] OPC_OR  = 8'h25;
  localparam logic [7:0] OPC_XOR = 8'h26;
  localparam logic [7:0] OPC_NOR = 8'h27;
  localparam logic [7:0] OPC_SRA = 8'h03;
  localparam logic [7:0] OPC_SRL = 8'h02;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  function automatic logic is_valid_opcode(input logic [7:0] b);
    case (b)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_XOR, OPC_NOR, OPC_SRA, OPC_SRL: is_valid_opcode = 1'b1;
      default:                            is_valid_opcode = 1'b0;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_timer;
  logic [N-1:0]     r_stage_a;
  logic [N-1:0]     r_stage_b;
  logic             r_invalid;
  logic [7:0]       r_flags;
  logic [N-1:0]     r_data_a;
  logic [N-1:0]     r_data_b;
  logic [NB_OP-1:0] r_op;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic             w_counting;
  logic             w_timeout;
  logic             w_op_valid;
  logic             w_stage_a;
  logic             w_stage_b;
  logic             w_commit;
  logic             w_capture;
  logic             w_send_res;
  logic             w_send_flg;
  logic             w_abort;
  logic [7:0]       w_result;
  logic [7:0]       w_flags;

  assign w_counting = (r_state == WAIT_B)   || (r_state == WAIT_OP) ||
                      (r_state == WAIT_RES) || (r_state == WAIT_FLG);
  assign w_timeout  = w_counting && (r_timer == TIMEOUT_LAST);
  assign w_op_valid = is_valid_opcode(rx_data);

  // An invalid opcode replaces the ALU response with a zero result and the ERR flag.
  assign w_result = r_invalid ? 8'h00 : alu_result[7:0];
  assign w_flags  = r_invalid ? 8'h80
                              : {1'b0, 4'b0000, alu_carry, alu_overflow, alu_zero};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_stage_a    = 1'b0;
    w_stage_b    = 1'b0;
    w_commit     = 1'b0;
    w_capture    = 1'b0;
    w_send_res   = 1'b0;
    w_send_flg   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_done) begin
          w_stage_a    = 1'b1;
          w_state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done) begin
          w_stage_b    = 1'b1;
          w_state_next = WAIT_OP;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      WAIT_OP: begin
        if (rx_done) begin
          w_commit     = 1'b1;
          w_state_next = EXEC;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      EXEC: begin
        w_capture    = 1'b1;
        w_send_res   = 1'b1;
        w_state_next = TX_RES;
      end
      TX_RES: w_state_next = WAIT_RES;
      WAIT_RES: begin
        if (tx_done) begin
          w_send_flg   = 1'b1;
          w_state_next = TX_FLG;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      TX_FLG: w_state_next = WAIT_FLG;
      WAIT_FLG: begin
        if (tx_done) begin
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counts only while parked in a wait state; any transition restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      r_timer <= '0;
    end else if (w_counting) begin
      r_timer <= r_timer + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_a  <= '0;
      r_stage_b  <= '0;
      r_invalid  <= 1'b0;
      r_flags    <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_op       <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_stage_a) r_stage_a <= rx_data[N-1:0];
      if (w_stage_b) r_stage_b <= rx_data[N-1:0];
      if (w_abort) begin
        r_stage_a <= '0;
        r_stage_b <= '0;
      end
      // The opcode byte and both staged operands land on the ALU in one edge.
      if (w_commit) begin
        r_invalid <= !w_op_valid;
        if (w_op_valid) begin
          r_data_a <= r_stage_a;
          r_data_b <= r_stage_b;
          r_op     <= rx_data[NB_OP-1:0];
        end
      end
      if (w_capture) r_flags <= w_flags;
      r_tx_start <= w_send_res || w_send_flg;
      if (w_send_res)      r_tx_data <= w_result;
      else if (w_send_flg) r_tx_data <= r_flags;
    end
  end

  assign data_a   = r_data_a;
  assign data_b   = r_data_b;
  assign op       = r_op;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: a behavioural ALU and UART transmitter
// surround the DUT, and a monitor checks every transmitted byte against a queue.
module tb_uart_alu_interface;

  localparam int N       = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 50;
  localparam int RESP_DLY = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_done;
  logic [7:0]       rx_data;
  logic             tx_done;
  logic [N-1:0]     alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry;
  logic [N-1:0]     data_a;
  logic [N-1:0]     data_b;
  logic [NB_OP-1:0] op;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       resp_en = 1'b1;
  logic       prev_tx = 1'b0;
  logic [8:0] sum;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opc;
    logic [7:0] res;
    logic [7:0] flg;
  } vec_t;

  always #5 clk = ~clk;

  uart_alu_interface #(.N(N), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .tx_done      (tx_done),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .data_a       (data_a),
    .data_b       (data_b),
    .op           (op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy)
  );

  // Behavioural ALU (carry on SUB means borrow).
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (op)
      6'h20: begin
        sum          = {1'b0, data_a} + {1'b0, data_b};
        alu_result   = sum[7:0];
        alu_carry    = sum[8];
        alu_overflow = (data_a[7] == data_b[7]) && (alu_result[7] != data_a[7]);
      end
      6'h22: begin
        alu_result   = data_a - data_b;
        alu_carry    = data_a < data_b;
        alu_overflow = (data_a[7] != data_b[7]) && (alu_result[7] != data_a[7]);
      end
      6'h24: alu_result = data_a & data_b;
      6'h25: alu_result = data_a | data_b;
      6'h26: alu_result = data_a ^ data_b;
      6'h27: alu_result = ~(data_a | data_b);
      6'h03: alu_result = 8'($signed(data_a) >>> data_b[2:0]);
      6'h02: alu_result = data_a >> data_b[2:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tx_start pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        check("tx_start_gap", {31'd0, prev_tx}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got byte 0x%0h, expected none at %0t", tx_data, $time);
        end else begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_tx = tx_start;
    end
  end

  // UART transmitter model: acknowledges each byte a few cycles after tx_start.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && resp_en) begin
        repeat (RESP_DLY) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    send_byte(a);
    @(negedge clk);
    send_byte(b);
    @(negedge clk);
    send_byte(o);
  endtask

  task automatic expect_tx(input logic [7:0] r, input logic [7:0] f);
    exp_q.push_back(r);
    exp_q.push_back(f);
  endtask

  task automatic wait_idle(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_q_empty(input string name);
    logic done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_regs(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [5:0] o);
    check({name, "_a"}, {24'd0, data_a}, {24'd0, a});
    check({name, "_b"}, {24'd0, data_b}, {24'd0, b});
    check({name, "_op"}, {26'd0, op}, {26'd0, o});
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h05, 8'h05, 8'h22, 8'h00, 8'h01};  // SUB -> Z
    vecs[1] = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h05};  // ADD -> C, Z
    vecs[2] = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00};  // OR
    vecs[3] = '{8'hFF, 8'h00, 8'h27, 8'h00, 8'h01};  // NOR -> Z
    vecs[4] = '{8'h55, 8'hAA, 8'h26, 8'hFF, 8'h00};  // XOR
    vecs[5] = '{8'h80, 8'h03, 8'h02, 8'h10, 8'h00};  // SRL
    vecs[6] = '{8'h80, 8'h01, 8'h03, 8'hC0, 8'h00};  // SRA
    vecs[7] = '{8'h7F, 8'h01, 8'h20, 8'h80, 8'h02};  // ADD -> V

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_regs("reset", 8'h00, 8'h00, 6'h00);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Basic ADD frame with latency check on the opcode byte.
    expect_tx(8'h3B, 8'h00);
    send_byte(8'h2A);
    @(negedge clk);
    send_byte(8'h11);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = 8'h20;
    @(posedge clk);
    #1;
    check("latency_exec_tx_start", {31'd0, tx_start}, 32'd0);
    check_regs("commit", 8'h2A, 8'h11, 6'h20);
    @(negedge clk);
    rx_done = 1'b0;
    @(posedge clk);
    #1;
    check("latency_tx_start", {31'd0, tx_start}, 32'd1);
    wait_idle("idle_add");

    foreach (vecs[i]) begin
      expect_tx(vecs[i].res, vecs[i].flg);
      send_frame(vecs[i].a, vecs[i].b, vecs[i].opc);
      wait_idle("idle_vec");
    end
    check_regs("after_vecs", 8'h7F, 8'h01, 6'h20);

    // Invalid opcodes keep the committed operands.
    expect_tx(8'h00, 8'h80);
    send_frame(8'h01, 8'h02, 8'h3F);
    wait_idle("idle_inv3f");
    check_regs("inv3f", 8'h7F, 8'h01, 6'h20);
    expect_tx(8'h00, 8'h80);
    send_frame(8'h01, 8'h02, 8'h60);
    wait_idle("idle_inv60");
    check_regs("inv60", 8'h7F, 8'h01, 6'h20);

    // Partial frame abandoned after the timeout.
    send_byte(8'h33);
    repeat (60) @(negedge clk);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    expect_tx(8'h02, 8'h00);
    send_frame(8'h0A, 8'h03, 8'h24);
    wait_idle("idle_and");
    check_regs("and", 8'h0A, 8'h03, 6'h24);

    // rx_done on the last counted cycle of WAIT_B wins over the timeout.
    expect_tx(8'h30, 8'h00);
    send_byte(8'h10);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h20);
    @(negedge clk);
    send_byte(8'h20);
    wait_idle("idle_priority");
    check_regs("priority", 8'h10, 8'h20, 6'h20);

    // Stalled transmitter: flags byte never requested after the timeout.
    resp_en = 1'b0;
    exp_q.push_back(8'h02);
    send_frame(8'h01, 8'h01, 8'h20);
    wait_idle("idle_tx_stall");
    resp_en = 1'b1;

    // Reset in WAIT_RES aborts immediately.
    resp_en = 1'b0;
    exp_q.push_back(8'h3B);
    send_frame(8'h2A, 8'h11, 8'h20);
    wait_q_empty("reach_wait_res");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_regs("async_reset", 8'h00, 8'h00, 6'h00);
    check("async_reset_tx_start", {31'd0, tx_start}, 32'd0);
    check("async_reset_tx_data", {24'd0, tx_data}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    resp_en = 1'b1;
    repeat (20) @(negedge clk);

    // Stray byte during WAIT_FLG is dropped.
    expect_tx(8'h3B, 8'h00);
    send_frame(8'h2A, 8'h11, 8'h20);
    wait_q_empty("reach_tx_flg");
    send_byte(8'h99);
    wait_idle("idle_stray");
    expect_tx(8'h3B, 8'h00);
    send_frame(8'h2A, 8'h11, 8'h20);
    wait_idle("idle_after_stray");
    check_regs("after_stray", 8'h2A, 8'h11, 6'h20);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
